// File: rtl/btn_conditioner.sv
// Multi-channel button/switch conditioner: synchroniser, debouncer, rise/fall pulses
// and optional held-button auto-repeat (built when BTN_REPEAT_EN is defined).
module btn_conditioner #(
   parameter int unsigned CHANNELS        = 8,
   parameter int unsigned NSYNC           = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
   input  logic                clk_100mhz,
   input  logic                reset,
   input  logic [CHANNELS-1:0] raw_in,
   input  logic [CHANNELS-1:0] repeat_en,
   output logic [CHANNELS-1:0] clean_out,
   output logic [CHANNELS-1:0] rise_out,
   output logic [CHANNELS-1:0] fall_out,
   output logic [CHANNELS-1:0] repeat_out
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_REPEAT_EN
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
   localparam logic [RPT_W-1:0] DELAY_MAX  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_MAX = RPT_W'(REPEAT_PERIOD - 1);
`else
   localparam int unsigned unused_rpt_cfg = REPEAT_DELAY + REPEAT_PERIOD;
   logic unused_repeat_en;
   assign unused_repeat_en = ^repeat_en;
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [NSYNC-1:0] sync_r;
      logic             sync_q;
      logic             cand;
      logic [CNT_W-1:0] cnt;
      logic             clean_r;
      logic             clean_d;
      logic             rise;

      // Metastability chain; last stage feeds the debouncer
      always_ff @(posedge clk_100mhz) begin
         if (reset) sync_r <= '0;
         else       sync_r <= {sync_r[NSYNC-2:0], raw_in[i]};
      end

      assign sync_q = sync_r[NSYNC-1];

      // Candidate must stay unchanged for DEBOUNCE_CYCLES samples before it is accepted
      always_ff @(posedge clk_100mhz) begin
         if (reset) begin
            cand    <= 1'b0;
            cnt     <= '0;
            clean_r <= 1'b0;
         end else if (sync_q != cand) begin
            cand <= sync_q;
            cnt  <= '0;
         end else if (cnt == CNT_MAX) begin
            clean_r <= cand;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end

      always_ff @(posedge clk_100mhz) begin
         if (reset) clean_d <= 1'b0;
         else       clean_d <= clean_r;
      end

      assign rise         = clean_r & ~clean_d;
      assign clean_out[i] = clean_r;
      assign rise_out[i]  = rise;
      assign fall_out[i]  = ~clean_r & clean_d;

`ifdef BTN_REPEAT_EN
      logic [RPT_W-1:0] rcnt;
      logic             first;
      logic             rpt_hit;

      assign rpt_hit = repeat_en[i] & clean_r &
                       (first ? (rcnt == PERIOD_MAX) : (rcnt == DELAY_MAX));

      // First pulse after REPEAT_DELAY, then every REPEAT_PERIOD while held and enabled
      always_ff @(posedge clk_100mhz) begin
         if (reset || rise || !clean_r || !repeat_en[i]) begin
            rcnt  <= '0;
            first <= 1'b0;
         end else if (rpt_hit) begin
            rcnt  <= '0;
            first <= 1'b1;
         end else begin
            rcnt <= rcnt + RPT_W'(1);
         end
      end

      assign repeat_out[i] = rise | rpt_hit;
`else
      assign repeat_out[i] = rise;
`endif
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus randomized
// stimulus, all cycles compared against a rule-level reference model.
module tb_btn_conditioner;

   localparam int unsigned CH = 2;
   localparam int unsigned NS = 2;
   localparam int unsigned DB = 4;
   localparam int unsigned RD = 20;
   localparam int unsigned RP = 8;
`ifdef BTN_REPEAT_EN
   localparam bit RPT_ON = 1'b1;
`else
   localparam bit RPT_ON = 1'b0;
`endif

   logic          clk_100mhz = 1'b0;
   logic          reset      = 1'b1;
   logic [CH-1:0] raw_in     = '0;
   logic [CH-1:0] repeat_en  = '0;
   logic [CH-1:0] clean_out, rise_out, fall_out, repeat_out;

   btn_conditioner #(
      .CHANNELS(CH), .NSYNC(NS), .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk_100mhz(clk_100mhz), .reset(reset), .raw_in(raw_in), .repeat_en(repeat_en),
      .clean_out(clean_out), .rise_out(rise_out), .fall_out(fall_out), .repeat_out(repeat_out)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   int checks = 0;
   int errors = 0;
   int cyc_no = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
      end
   endtask

   // Reference model: raw samples delayed NS edges, level accepted once DB+1 consecutive
   // synchronised samples agree (the reset edge counts as a 0 sample).
   bit raw_h [CH][NS];
   bit sq_h  [CH][DB+1];
   int sq_n  [CH];
   bit m_clean [CH];
   bit m_cd    [CH];
   int anchor  [CH];

   always @(posedge clk_100mhz) begin : model_seq
      bit sq;
      bit same;
      cyc_no++;
      for (int c = 0; c < CH; c++) begin
         if (reset) begin
            for (int j = 0; j < NS; j++) raw_h[c][j] = 1'b0;
            sq_h[c][0] = 1'b0;
            sq_n[c]    = 1;
            m_clean[c] = 1'b0;
            m_cd[c]    = 1'b0;
         end else begin
            sq = raw_h[c][NS-1];
            for (int j = NS-1; j > 0; j--) raw_h[c][j] = raw_h[c][j-1];
            raw_h[c][0] = raw_in[c];
            for (int j = DB; j > 0; j--) sq_h[c][j] = sq_h[c][j-1];
            sq_h[c][0] = sq;
            if (sq_n[c] < DB+1) sq_n[c]++;
            m_cd[c] = m_clean[c];
            if (sq_n[c] == DB+1) begin
               same = 1'b1;
               for (int j = 1; j <= DB; j++) if (sq_h[c][j] != sq_h[c][0]) same = 1'b0;
               if (same) m_clean[c] = sq_h[c][0];
            end
         end
      end
   end

   // Repeat timing from the start of the current held-and-enabled run
   always @(negedge clk_100mhz) begin : model_chk
      logic [CH-1:0] e_clean, e_rise, e_fall, e_rep;
      int d;
      for (int c = 0; c < CH; c++) begin
         e_clean[c] = m_clean[c];
         e_rise[c]  = m_clean[c] & ~m_cd[c];
         e_fall[c]  = ~m_clean[c] & m_cd[c];
         e_rep[c]   = e_rise[c];
         if (RPT_ON && !e_rise[c] && m_clean[c] && repeat_en[c]) begin
            d = cyc_no - anchor[c];
            e_rep[c] = (d == RD) || (d > RD && ((d - RD) % RP) == 0);
         end
         if (e_rise[c] || !(m_clean[c] && repeat_en[c])) anchor[c] = cyc_no;
      end
      check_eq("m_clean", 32'(clean_out), 32'(e_clean));
      check_eq("m_rise", 32'(rise_out), 32'(e_rise));
      check_eq("m_fall", 32'(fall_out), 32'(e_fall));
      check_eq("m_repeat", 32'(repeat_out), 32'(e_rep));
   end

   task automatic tick();
      @(posedge clk_100mhz);
      #1;
   endtask

   task automatic settle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin : main
      int t;
      int r0, r1;
      int n_rise, n_fall, n_clean;
      int mode;

      // Reset state
      repeat (3) @(posedge clk_100mhz);
      @(negedge clk_100mhz);
      check_eq("rst_state", 32'({clean_out, rise_out, fall_out, repeat_out}), 32'd0);
      tick();
      reset     = 1'b0;
      raw_in[0] = 1'b1;

      // Debounce latency, repeat disabled, then enabled at edge 38 (rise cycle t=7)
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (k == 38) repeat_en[0] = 1'b1;
         @(negedge clk_100mhz);
         if (k == 1) check_eq("post_rst", 32'({clean_out, rise_out, fall_out, repeat_out}), 32'd0);
         check_eq("lat_clean", 32'(clean_out[0]), 32'(k >= 7));
         check_eq("lat_rise", 32'(rise_out[0]), 32'(k == 7));
         check_eq("dis_repeat", 32'(repeat_out[0]),
                  32'(RPT_ON ? (k == 7 || k == 57 || k == 65) : (k == 7)));
      end

      // Release: exactly one fall pulse
      tick();
      raw_in[0] = 1'b0;
      n_fall = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         @(negedge clk_100mhz);
         n_fall += int'(fall_out[0]);
      end
      check_eq("rel_fall", 32'(n_fall), 32'd1);

      // Auto-repeat with repeat_en held high
      tick();
      raw_in[0] = 1'b1;
      t = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         @(negedge clk_100mhz);
         if (rise_out[0]) begin
            t = k;
            check_eq("ar_rep_t", 32'(repeat_out[0]), 32'd1);
            break;
         end
      end
      check_eq("ar_rise_lat", 32'(t), 32'd7);
      for (int d = 1; d < 60; d++) begin
         tick();
         @(negedge clk_100mhz);
         check_eq("ar_repeat", 32'(repeat_out[0]),
                  32'(RPT_ON && (d == 20 || d == 28 || d == 36 || d == 44 || d == 52)));
      end
      tick();
      raw_in[0] = 1'b0;
      n_fall = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         @(negedge clk_100mhz);
         n_fall += int'(fall_out[0]);
      end
      check_eq("ar_rel_fall", 32'(n_fall), 32'd1);

      // Glitch rejection on channel 1: 4-cycle pulse rejected, 5-cycle pulse accepted
      for (int w = 4; w <= 5; w++) begin
         n_rise = 0; n_fall = 0; n_clean = 0;
         for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1)     raw_in[1] = 1'b1;
            if (k == 1 + w) raw_in[1] = 1'b0;
            @(negedge clk_100mhz);
            n_rise  += int'(rise_out[1]);
            n_fall  += int'(fall_out[1]);
            n_clean += int'(clean_out[1]);
         end
         check_eq($sformatf("glitch%0d_rise", w), 32'(n_rise), 32'(w == 5));
         check_eq($sformatf("glitch%0d_fall", w), 32'(n_fall), 32'(w == 5));
         check_eq($sformatf("glitch%0d_clean", w), 32'(n_clean > 0), 32'(w == 5));
      end

      // Reset mid-hold at t+25
      tick();
      raw_in[0] = 1'b1;
      t = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         @(negedge clk_100mhz);
         if (rise_out[0]) begin t = k; break; end
      end
      check_eq("rm_rise_lat", 32'(t), 32'd7);
      settle(24);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk_100mhz);
      check_eq("rm_cleared", 32'({clean_out, rise_out, fall_out, repeat_out}), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         @(negedge clk_100mhz);
         check_eq("rm_rerise", 32'(rise_out[0]), 32'(k == 7));
      end

      // Simultaneous channels
      tick();
      raw_in = '0;
      settle(15);
      raw_in = '1;
      r0 = -1; r1 = -1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         @(negedge clk_100mhz);
         if (rise_out[0] && r0 < 0) r0 = k;
         if (rise_out[1] && r1 < 0) r1 = k;
      end
      check_eq("sim_rise0", 32'(r0), 32'd7);
      check_eq("sim_rise1", 32'(r1), 32'd7);

      // Randomized traffic with varying toggle density, enable changes and rare resets
      for (int seg = 0; seg < 20; seg++) begin
         mode = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 8 : 60);
         for (int k = 0; k < 100; k++) begin
            tick();
            reset = ($urandom_range(0, 499) == 0);
            for (int c = 0; c < CH; c++) begin
               if ($urandom_range(0, mode - 1) == 0) raw_in[c] = ~raw_in[c];
               if ($urandom_range(0, 39) == 0) repeat_en[c] = ~repeat_en[c];
            end
         end
      end
      tick();
      reset = 1'b0;
      settle(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
